// File: rtl/i2s_rx_deserializer.sv
// I2S (Philips format) receiver. BCLK, LRCLK and SDATA are oversampled in the state_clk domain.
// Left and right words are deserialized, then presented together as one sample pair.
module i2s_rx_deserializer #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              state_clk,
  input  logic              reset,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] audio_l,
  output logic [DATA_W-1:0] audio_r,
  output logic              sample_valid,
  output logic              lr_out,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
  logic                   bclk_s, lr_s, sd_s, bclk_d, rise;
  logic [DATA_W-1:0]      shreg, l_hold, word_n, word;
  logic [CNT_W-1:0]       bit_cnt, cnt_n;
  logic                   lr_prev, synced, l_fresh;

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lr_s   = lr_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_d;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    word_n = shreg;
    cnt_n  = bit_cnt;
    if (bit_cnt < FULL) begin
      word_n = {shreg[DATA_W-2:0], sd_s};
      cnt_n  = bit_cnt + CNT_W'(1);
    end
    // Left-justify short words; zeros fill the missing LSBs.
    word = word_n << (FULL - cnt_n);
  end

  // NOTE: every register here, including the holding registers, is reset; there is no RAM to exempt.
  always_ff @(posedge state_clk) begin
    if (!reset) begin
      bclk_sync    <= '0;
      lr_sync      <= '0;
      sd_sync      <= '0;
      bclk_d       <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      lr_prev      <= 1'b0;
      synced       <= 1'b0;
      l_hold       <= '0;
      l_fresh      <= 1'b0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      lr_out       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lr_sync      <= {lr_sync[SYNC_STAGES-2:0], lrclk};
      sd_sync      <= {sd_sync[SYNC_STAGES-2:0], sdata};
      bclk_d       <= bclk_s;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        shreg   <= word_n;
        bit_cnt <= cnt_n;
        // The bit at a channel-change rise is the LSB of the word that just ended.
        if (lr_s != lr_prev) begin
          bit_cnt <= '0;
          lr_prev <= lr_s;
          if (!synced) begin
            synced <= 1'b1;
          end else begin
            frame_err <= (cnt_n < FULL);
            if (!lr_prev) begin
              l_hold  <= word;
              l_fresh <= 1'b1;
              lr_out  <= 1'b0;
            end else if (l_fresh) begin
              audio_l      <= l_hold;
              audio_r      <= word;
              sample_valid <= 1'b1;
              lr_out       <= 1'b1;
              l_fresh      <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Receives an I2S serial audio stream (BCLK, LRCLK, SDATA) from the codec and converts it into parallel 16-bit left/right samples in the `state_clk` domain. It sits directly upstream of the IIR filter state machines. Its `audio_r` and `audio_l` outputs drive the filter's `audio_in`, and its `lr_out` drives the filter's `lr_clk` one-shot. The I2S pins are oversampled with `state_clk`; no clock is derived from BCLK.

## Interface
Parameters:
- `DATA_W`, 16: bits captured per channel word, MSB first.
- `SYNC_STAGES`, 2: synchronizer flops per input pin (minimum 2).

Ports:
- `state_clk`, in, 1: system clock. Must be at least 4× the BCLK frequency; each BCLK phase must last at least 2 `state_clk` periods.
- `reset`, in, 1: synchronous, active-low reset, sampled on rising `state_clk`.
- `bclk`, in, 1: I2S bit clock, asynchronous.
- `lrclk`, in, 1: I2S word select, asynchronous. 0 = left, 1 = right.
- `sdata`, in, 1: I2S serial data, asynchronous.
- `audio_l`, out, `DATA_W`: last complete left sample, 2's complement.
- `audio_r`, out, `DATA_W`: last complete right sample, 2's complement.
- `sample_valid`, out, 1: one-cycle pulse when `audio_l` and `audio_r` update together.
- `lr_out`, out, 1: frame strobe for the downstream filter. Goes to 1 on a pair update and to 0 on a left-word commit.
- `frame_err`, out, 1: one-cycle pulse when a word is committed with fewer than `DATA_W` bits.

## Operation
- **Synchronization.** `bclk`, `lrclk` and `sdata` each pass through `SYNC_STAGES` flops, giving `bclk_s`, `lr_s` and `sd_s`. `bclk_d` is `bclk_s` delayed one cycle. A rise event is `bclk_s & ~bclk_d`. All other logic acts only in rise cycles.
- **Input format: Philips I2S.** The word-select change precedes the MSB by one BCLK. The bit sampled at the rise where `lr_s` first differs from `lr_prev` is the LSB of the previous channel's word.
- **Per-rise registers.** `shreg` (`DATA_W`), `bit_cnt` (0..`DATA_W`, saturating), `lr_prev`, `synced`, `l_hold`, `l_fresh`.
- **Shift rule.** On every rise, if `bit_cnt < DATA_W`, then `shreg <= {shreg[DATA_W-2:0], sd_s}` and `bit_cnt++`. Once `bit_cnt = DATA_W`, further bits are ignored, so 24- or 32-bit slots yield the upper 16 bits.
- **Channel-change rise** (`lr_s != lr_prev`):
  - Apply the shift rule first, giving `word_n` and `cnt_n`.
  - If `synced = 0`: set `synced <= 1`, `bit_cnt <= 0`, `lr_prev <= lr_s`. No commit, because the first word after reset is partial.
  - If `synced = 1`: commit `word = word_n << (DATA_W - cnt_n)`, i.e. left-justified and zero-filled. If `cnt_n < DATA_W`, pulse `frame_err`. Then `bit_cnt <= 0` and `lr_prev <= lr_s`.
- **Left commit** (`lr_prev = 0`): `l_hold <= word`, `l_fresh <= 1`, `lr_out <= 0`.
- **Right commit** (`lr_prev = 1`):
  - If `l_fresh = 1`: `audio_l <= l_hold`, `audio_r <= word`, pulse `sample_valid`, set `lr_out <= 1`, clear `l_fresh`.
  - If `l_fresh = 0`: the right word is discarded and outputs are unchanged.
- **Reset.**
  - Every output is 0: `audio_l = 0`, `audio_r = 0`, `sample_valid = 0`, `lr_out = 0`, `frame_err = 0`.
  - Internally, all synchronizer flops, `bclk_d`, `shreg`, `bit_cnt`, `lr_prev`, `synced`, `l_hold` and `l_fresh` are 0.
  - Reset mid-word discards the partial word. The block resynchronizes on the next channel change.
- **Glitches.** An LRCLK change with no BCLK rise is not acted on. A change seen at a rise is always treated as a slot boundary.

## Timing
- Let t0 be the `state_clk` edge at which the first synchronizer flop captures `bclk = 1` for a channel-change rise.
  - The rise is detected in the cycle after edge t0+SYNC_STAGES-1.
  - The commit registers at edge t0+SYNC_STAGES.
  - `sample_valid`, `frame_err`, `lr_out`, `audio_l` and `audio_r` change at that same edge.
  - Total latency is `SYNC_STAGES` cycles from pin capture (2 at default).
- `sample_valid` and `frame_err` are high for exactly one cycle.
- `lr_out` is a level that stays high from a pair update until the next left commit.
- `audio_l` and `audio_r` are stable between `sample_valid` pulses.

## Test plan
- **Nominal frame.** BCLK = `state_clk`/8, 16-bit slots, left 0x8001 and right 0x7FFE, three frames.
  - The first pair is discarded (sync).
  - Afterwards, each frame gives `audio_l = 0x8001`, `audio_r = 0x7FFE`, one `sample_valid` pulse, and `lr_out` rising in the same cycle.
- **32-bit slots.** Left 0x1234_ABCD, right 0xFEDC_0000 → `audio_l = 0x1234`, `audio_r = 0xFEDC`, `frame_err` never asserted.
- **Short slot.** The left slot has only 12 BCLKs with MSB-first bits 0xABC → `audio_l = 0xABC0` and `frame_err` pulses once at the left commit.
- **Latency.** Drive one channel-change rise aligned to a `state_clk` edge → `sample_valid` asserts exactly 2 cycles later (`SYNC_STAGES = 2`).
- **Reset mid-right-word.** Hold `reset` low for 3 cycles during a right slot →
  - All outputs read 0.
  - No `sample_valid` appears until a full left and right pair has been received after the first post-reset channel change.
- **Minimum oversampling.** BCLK = `state_clk`/4 with random data for 1000 frames → every pair matches the reference model and there are no `frame_err` pulses.
